// File: rtl/oc8051_xram_arbiter.sv
// Round-robin arbiter that shares the single XRAM/page-table port among N bus masters.
// Page-table verdicts gate the memory strobe, and hung accesses are completed by timeout.
module oc8051_xram_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_stb,
    input  logic [N-1:0]      req_wr,
    input  logic [16*N-1:0]   req_addr,
    input  logic [8*N-1:0]    req_wdata,
    output logic [N-1:0]      req_ack,
    output logic [N-1:0]      req_err,
    output logic [8*N-1:0]    req_rdata,
    output logic              xram_stb,
    output logic              mem_stb,
    output logic              xram_wr,
    output logic [15:0]       xram_addr,
    output logic [7:0]        xram_data_out,
    output logic [2:0]        accesser,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              xram_ack,
    input  logic [7:0]        xram_data_in,
    output logic              busy,
    output logic [7:0]        deny_cnt
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [2:0]    g_q, g_d;
    logic [2:0]    rr_q, rr_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    deny_q, deny_d;

    // Widen request vectors to eight slots so a 3-bit grant index selects them exactly.
    logic [7:0]   stb_pad;
    logic [7:0]   wr_pad;
    logic [127:0] addr_pad;
    logic [63:0]  wdata_pad;

    assign stb_pad   = 8'(req_stb);
    assign wr_pad    = 8'(req_wr);
    assign addr_pad  = 128'(req_addr);
    assign wdata_pad = 64'(req_wdata);

    logic       pick_valid;
    logic [2:0] pick_idx;
    logic [3:0] cand;

    // Scan from the highest offset down so the requester closest to rr wins.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, rr_q} + 4'(k);
            if (cand >= 4'(N)) cand = cand - 4'(N);
            if (stb_pad[cand[2:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[2:0];
            end
        end
    end

    logic in_access;
    logic perm;
    logic done;
    logic fail;
    logic fire;

    assign in_access     = (state_q == ST_ACCESS);
    assign xram_stb      = in_access;
    assign xram_wr       = in_access & wr_pad[g_q];
    assign xram_addr     = in_access ? addr_pad[{g_q, 4'b0000} +: 16] : 16'h0000;
    assign xram_data_out = in_access ? wdata_pad[{g_q, 3'b000} +: 8] : 8'h00;
    assign accesser      = in_access ? g_q : 3'd0;
    assign perm          = xram_wr ? wr_en : rd_en;
    assign mem_stb       = in_access & perm;
    assign busy          = in_access;
    assign deny_cnt      = deny_q;

    // Denial wins over ack; timeout only when the access was permitted but never acked.
    assign done = in_access & (~perm | xram_ack | (tcnt_q == TLAST));
    assign fail = ~perm | ~xram_ack;
    // An access aborted by reset must not complete toward its master.
    assign fire = done & ~rst;

    always_comb begin
        req_ack   = '0;
        req_err   = '0;
        req_rdata = '0;
        for (int i = 0; i < N; i++) begin
            if (in_access && g_q == 3'(i)) begin
                req_ack[i]          = fire;
                req_err[i]          = fire & fail;
                req_rdata[8*i +: 8] = xram_data_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        rr_d    = rr_q;
        tcnt_d  = tcnt_q;
        deny_d  = deny_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_ACCESS;
                    g_d     = pick_idx;
                    tcnt_d  = '0;
                end
            end
            default: begin
                if (done) begin
                    state_d = ST_IDLE;
                    rr_d    = (g_q == 3'(N - 1)) ? 3'd0 : g_q + 3'd1;
                    if (!perm && deny_q != 8'hFF) deny_d = deny_q + 8'd1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            rr_q    <= '0;
            tcnt_q  <= '0;
            deny_q  <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            rr_q    <= rr_d;
            tcnt_q  <= tcnt_d;
            deny_q  <= deny_d;
        end
    end

endmodule

// File: tb/tb_oc8051_xram_arbiter.sv
// Self-checking bench for oc8051_xram_arbiter: directed vector table, corner-case
// sequences and randomized traffic compared against a cycle-level behavioural model.
module tb_oc8051_xram_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_stb, req_wr;
    logic [16*N-1:0]  req_addr;
    logic [8*N-1:0]   req_wdata;
    logic [N-1:0]     req_ack, req_err;
    logic [8*N-1:0]   req_rdata;
    logic             xram_stb, mem_stb, xram_wr;
    logic [15:0]      xram_addr;
    logic [7:0]       xram_data_out;
    logic [2:0]       accesser;
    logic             wr_en, rd_en, xram_ack;
    logic [7:0]       xram_data_in;
    logic             busy;
    logic [7:0]       deny_cnt;

    always #5 clk = ~clk;

    oc8051_xram_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_stb(req_stb), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .req_err(req_err), .req_rdata(req_rdata),
        .xram_stb(xram_stb), .mem_stb(mem_stb), .xram_wr(xram_wr),
        .xram_addr(xram_addr), .xram_data_out(xram_data_out), .accesser(accesser),
        .wr_en(wr_en), .rd_en(rd_en), .xram_ack(xram_ack), .xram_data_in(xram_data_in),
        .busy(busy), .deny_cnt(deny_cnt)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct { int id; bit err; int at; } done_t;
    done_t log_q[$];

    typedef struct {
        logic [N-1:0]   stb, wr;
        logic           we, re, xack;
        logic [7:0]     din;
        logic           xstb, mstb, xwr;
        logic [2:0]     acc;
        logic [15:0]    addr;
        logic [7:0]     xdo;
        logic [N-1:0]   ack, err;
        logic [8*N-1:0] rdata;
        logic           bsy;
        logic [7:0]     dcnt;
    } vec_t;
    vec_t vt[8];

    // Behavioural model: who holds the port, how long it has waited, and the fairness pointer.
    bit  m_busy, m_perm, m_done;
    int  m_g, m_rr, m_tc, m_dc;
    logic           e_xstb, e_mstb, e_xwr, e_busy;
    logic [2:0]     e_acc;
    logic [15:0]    e_addr;
    logic [7:0]     e_wd, e_dc;
    logic [N-1:0]   e_ack, e_err;
    logic [8*N-1:0] e_rdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_eval();
        e_xstb = 1'b0; e_mstb = 1'b0; e_xwr = 1'b0; e_acc = 3'd0; e_addr = 16'h0;
        e_wd = 8'h0; e_ack = '0; e_err = '0; e_rdata = '0;
        m_perm = 1'b0; m_done = 1'b0;
        if (m_busy) begin
            e_xstb = 1'b1;
            e_acc  = 3'(m_g);
            e_addr = req_addr[16*m_g +: 16];
            e_xwr  = req_wr[m_g];
            e_wd   = req_wdata[8*m_g +: 8];
            m_perm = e_xwr ? wr_en : rd_en;
            e_mstb = m_perm;
            e_rdata[8*m_g +: 8] = xram_data_in;
            m_done = !m_perm || xram_ack || (m_tc == TIMEOUT - 1);
            if (m_done && !rst) begin
                e_ack[m_g] = 1'b1;
                e_err[m_g] = !m_perm || !xram_ack;
            end
        end
        e_busy = m_busy;
        e_dc   = 8'(m_dc);
    endtask

    task automatic model_advance();
        if (rst) begin
            m_busy = 1'b0; m_g = 0; m_rr = 0; m_tc = 0; m_dc = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int id;
                id = (m_rr + k) % N;
                if (req_stb[id]) begin
                    m_g = id; m_busy = 1'b1; m_tc = 0;
                    break;
                end
            end
        end else if (m_done) begin
            if (!m_perm && m_dc < 255) m_dc++;
            m_rr   = (m_g + 1) % N;
            m_busy = 1'b0;
        end else begin
            m_tc++;
        end
    endtask

    task automatic settle();
        done_t d;
        #4;
        model_eval();
        if (xram_stb === 1'b1 && req_ack != '0) begin
            d.id = int'(accesser); d.err = |req_err; d.at = cyc;
            log_q.push_back(d);
        end
    endtask

    task automatic finish_cycle();
        model_advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_model();
        check("xram_stb", xram_stb, e_xstb);
        check("mem_stb", mem_stb, e_mstb);
        check("xram_wr", xram_wr, e_xwr);
        check("accesser", accesser, e_acc);
        check("xram_addr", xram_addr, e_addr);
        check("xram_data_out", xram_data_out, e_wd);
        check("req_ack", req_ack, e_ack);
        check("req_err", req_err, e_err);
        check("req_rdata", req_rdata, e_rdata);
        check("busy", busy, e_busy);
        check("deny_cnt", deny_cnt, e_dc);
    endtask

    task automatic tick();
        settle();
        check_model();
        finish_cycle();
    endtask

    logic [N-1:0] pend;
    bit           stall;
    int           exp_rr[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1'b1; req_stb = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        wr_en = 1'b0; rd_en = 1'b0; xram_ack = 1'b0; xram_data_in = 8'h00;
        pend = '0; stall = 1'b0;
        m_busy = 1'b0; m_g = 0; m_rr = 0; m_tc = 0; m_dc = 0;
        #1;
        settle();
        finish_cycle();
        tick();
        rst = 1'b0;

        // Single read with a two-cycle memory wait, then a denied write from requester 2.
        req_addr  = {16'hC000, 16'h8000, 16'h5678, 16'h1234};
        req_wdata = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        vt[0] = '{4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00, 4'b0000, 4'b0000, 32'h0, 1'b0, 8'd0};
        vt[1] = '{4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 16'h1234, 8'hA0, 4'b0000, 4'b0000, 32'h0, 1'b1, 8'd0};
        vt[2] = vt[1];
        vt[3] = '{4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 3'd0, 16'h1234, 8'hA0, 4'b0001, 4'b0000, 32'h5A, 1'b1, 8'd0};
        vt[4] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00, 4'b0000, 4'b0000, 32'h0, 1'b0, 8'd0};
        vt[5] = '{4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00, 4'b0000, 4'b0000, 32'h0, 1'b0, 8'd0};
        vt[6] = '{4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 1'b1, 3'd2, 16'h8000, 8'hC2, 4'b0100, 4'b0100, 32'h0077_0000, 1'b1, 8'd0};
        vt[7] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00, 4'b0000, 4'b0000, 32'h0, 1'b0, 8'd1};
        for (int v = 0; v < 8; v++) begin
            req_stb = vt[v].stb; req_wr = vt[v].wr; wr_en = vt[v].we; rd_en = vt[v].re;
            xram_ack = vt[v].xack; xram_data_in = vt[v].din;
            settle();
            check($sformatf("tbl%0d_xram_stb", v), xram_stb, vt[v].xstb);
            check($sformatf("tbl%0d_mem_stb", v), mem_stb, vt[v].mstb);
            check($sformatf("tbl%0d_xram_wr", v), xram_wr, vt[v].xwr);
            check($sformatf("tbl%0d_accesser", v), accesser, vt[v].acc);
            check($sformatf("tbl%0d_xram_addr", v), xram_addr, vt[v].addr);
            check($sformatf("tbl%0d_xram_data_out", v), xram_data_out, vt[v].xdo);
            check($sformatf("tbl%0d_req_ack", v), req_ack, vt[v].ack);
            check($sformatf("tbl%0d_req_err", v), req_err, vt[v].err);
            check($sformatf("tbl%0d_req_rdata", v), req_rdata, vt[v].rdata);
            check($sformatf("tbl%0d_busy", v), busy, vt[v].bsy);
            check($sformatf("tbl%0d_deny_cnt", v), deny_cnt, vt[v].dcnt);
            finish_cycle();
        end

        // Round-robin from reset with all four masters requesting and instant memory acks.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_stb = 4'b1111; req_wr = '0; wr_en = 1'b1; rd_en = 1'b1; xram_ack = 1'b1;
        log_q.delete();
        begin
            int start;
            start = cyc;
            repeat (10) tick();
            check("rr_count", log_q.size(), 5);
            for (int i = 0; i < log_q.size() && i < 5; i++) begin
                check($sformatf("rr_id%0d", i), log_q[i].id, exp_rr[i]);
                check($sformatf("rr_at%0d", i), log_q[i].at - start, 1 + 2 * i);
            end
        end
        req_stb = '0;

        // Timeout on requester 1, after which pending requester 2 is granted.
        req_stb = 4'b0110; xram_ack = 1'b0;
        log_q.delete();
        begin
            int start;
            start = cyc;
            repeat (17) tick();
            req_stb = 4'b0100; xram_ack = 1'b1;
            repeat (2) tick();
            check("to_count", log_q.size(), 2);
            if (log_q.size() == 2) begin
                check("to_id", log_q[0].id, 1);
                check("to_err", log_q[0].err, 1);
                check("to_at", log_q[0].at - start, TIMEOUT);
                check("next_id", log_q[1].id, 2);
                check("next_err", log_q[1].err, 0);
                check("next_at", log_q[1].at - start, TIMEOUT + 2);
            end
        end
        req_stb = '0;

        // 300 denied reads saturate deny_cnt at 255.
        req_stb = 4'b0001; req_wr = '0; rd_en = 1'b0; wr_en = 1'b1;
        log_q.delete();
        repeat (508) tick();
        check("deny_254", deny_cnt, 254);
        repeat (2) tick();
        check("deny_255", deny_cnt, 255);
        repeat (90) tick();
        check("deny_sat", deny_cnt, 255);
        check("deny_acks", log_q.size(), 300);
        req_stb = '0; rd_en = 1'b1;

        // Reset during an access that would otherwise complete: no ack, everything cleared.
        req_stb = 4'b0010; xram_ack = 1'b0;
        repeat (2) tick();
        log_q.delete();
        xram_ack = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        req_stb = '0;
        check("rst_no_ack", log_q.size(), 0);
        check("rst_xram_stb", xram_stb, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_accesser", accesser, 3'd0);
        check("rst_addr", xram_addr, 16'h0);
        check("rst_deny_cnt", deny_cnt, 8'd0);
        req_stb = 4'b1111;
        repeat (8) tick();
        check("post_rst_count", log_q.size(), 4);
        for (int i = 0; i < log_q.size() && i < 4; i++)
            check($sformatf("post_rst_id%0d", i), log_q[i].id, i);
        req_stb = '0;

        // Randomized traffic: masters hold requests until acked, memory stalls in bursts.
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    req_wr[i] = 1'($urandom_range(0, 1));
                    req_addr[16*i +: 16] = 16'($urandom);
                    req_wdata[8*i +: 8] = 8'($urandom);
                end
            end
            req_stb = pend;
            wr_en = ($urandom_range(0, 9) != 0);
            rd_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) stall = !stall;
            xram_ack = !stall && ($urandom_range(0, 2) == 0);
            xram_data_in = 8'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            tick();
            pend = pend & ~e_ack;
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oc8051_xram_arbiter.md
# oc8051_xram_arbiter

Shares the single XRAM/page-table port between up to eight bus masters (CPU at ID 0, accelerators/DMA at IDs 1..N-1). Requests are granted round-robin. Each access drives the requester ID on `accesser`. Memory strobes are gated by the page-table `wr_en`/`rd_en` verdicts, so denied accesses never reach memory but are still presented to the page table for illegal-access logging. The block sits between the masters and the page table/XRAM, and also completes hung accesses by timeout.

## Interface
- N, 4, number of requesters (2..8); requester i has ID i, driven on `accesser`.
- TIMEOUT, 16, maximum ACCESS cycles without `xram_ack` before the access is forced to complete with error (2..256).
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_stb  in  N  per-requester strobe; held high until that requester's ack.
- req_wr  in  N  1 = write, 0 = read.
- req_addr  in  16*N  address, requester i at [16i+15:16i].
- req_wdata  in  8*N  write data, requester i at [8i+7:8i].
- req_ack  out  N  one-cycle completion pulse, one-hot.
- req_err  out  N  asserted together with req_ack when the access was denied or timed out.
- req_rdata  out  8*N  read data; the granted slice is `xram_data_in`, others 0.
- xram_stb  out  1  access presented to the page table (including denied ones).
- mem_stb  out  1  xram_stb & permitted; strobe to the memory/peripheral.
- xram_wr  out  1  granted req_wr.
- xram_addr  out  16  granted address.
- xram_data_out  out  8  granted write data.
- accesser  out  3  granted requester ID.
- wr_en, rd_en  in  1  page-table verdict for the current xram_addr (combinational).
- xram_ack  in  1  completion from the memory/page-table side.
- busy  out  1  state == ACCESS.
- deny_cnt  out  8  saturating count of denied accesses.

## Operation
- States: IDLE and ACCESS.
- Registers: grant index `g` (3 bits), round-robin pointer `rr`, timeout counter `tcnt`, deny_cnt.
- IDLE:
  - If any req_stb is set, pick the first set requester searching rr, rr+1, ... mod N.
  - Latch it into g, clear tcnt, go to ACCESS.
  - All xram outputs are 0 and no ack is issued.
- ACCESS: xram_stb=1; xram_addr, xram_wr, xram_data_out and accesser are taken combinationally from requester g.
  - `perm` = xram_wr ? wr_en : rd_en.
  - mem_stb = perm.
- Completion happens in the same ACCESS cycle; the first matching condition wins:
  - deny: !perm → req_ack[g]=1, req_err[g]=1, deny_cnt+1 (saturating at 255).
  - ok: perm && xram_ack → req_ack[g]=1, req_err[g]=0.
  - timeout: perm && !xram_ack && tcnt==TIMEOUT-1 → req_ack[g]=1, req_err[g]=1.
  - Otherwise tcnt+1 and stay in ACCESS.
- On completion: rr ← (g+1) mod N, go to IDLE.
- A denied access lasts exactly one ACCESS cycle. The page table sees one strobe and logs one illegal access with accesser=g.
- If req_stb[g] drops while in ACCESS, the access still completes normally; the stray ack is harmless.
- Request inputs for non-granted requesters are ignored.
- Reset:
  - state=IDLE, g=0, rr=0, tcnt=0, deny_cnt=0.
  - All outputs are 0 the cycle after the reset edge, including mid-ACCESS. No ack is issued for an aborted access.

## Timing
- Minimum access: 2 cycles.
  - Cycle 0: IDLE samples req_stb.
  - Cycle 1: ACCESS with same-cycle ack.
- No back-to-back grants: every access is followed by at least one IDLE cycle.
- Latency from req_stb to ack = 2 + (xram_ack wait cycles), capped at 1 + TIMEOUT.
- Worst-case wait for a continuously requesting master is N-1 other accesses (fairness bound).
- req_ack, req_err, req_rdata, mem_stb and xram_* are combinational in ACCESS. State, g, rr, tcnt and deny_cnt are registered.

## Test plan
- Single read: CPU (ID0) reads 0x1234 with rd_en=1; memory acks 2 cycles after xram_stb → req_ack[0] in cycle 3, err=0, req_rdata slice 0 = xram_data_in, accesser=0.
- Denied write: requester 2 writes 0x8000 with wr_en=0 → xram_stb for 1 cycle, mem_stb=0, req_ack[2]=req_err[2]=1 same cycle, accesser=2, deny_cnt=1.
- Round-robin: all four requesters hold req_stb; memory acks immediately → grant order 0,1,2,3,0, one access every 2 cycles.
- Timeout: perm=1, xram_ack stuck low, TIMEOUT=16 → ack+err on the 16th ACCESS cycle, then IDLE; the next requester is granted.
- deny_cnt saturation: 300 denied accesses → deny_cnt=255.
- Reset mid-access: assert rst during ACCESS → no ack, all outputs 0 next cycle, rr=0; after rst drops, a pending requester 3 is granted only after requesters 0..2 (if requesting).
